cv_ctrl_scan: RTL

Console-side controller-port scanner for the ColecoVision core. It drives the two per-player select lines (keypad-select, joystick-select) and waits for the port lines to settle. It then samples the four data lines and the fire line in each mode, and decodes the 4-bit keypad code back to a key index. It sits beside `cv_console` as the reader of the controller-port encoder in the sim top, so a bench can close the loop joystick → port → decoded state.

---
 rtl/cv_ctrl_scan.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/cv_ctrl_scan.sv
// cv_ctrl_scan: ColecoVision controller-port scanner.
// Drives keypad-select (P5) and joystick-select (P8) for both players in
// parallel. After SETTLE enable ticks it samples the data lines (P1..P4) and
// the fire line (P6), then decodes the keypad nibble into a key index.
// Optional macro CTRL_SCAN_DEBOUNCE_EN: outputs update only when two
// consecutive scans return the same raw result.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | both selects high, waiting for scan_req_i on an enable tick
// S_SEL_KEY | keypad select low, settle countdown, sample at terminal count
// S_GAP     | one enable tick with both selects high
// S_SEL_JOY | joystick select low, settle countdown, sample at terminal count
// S_DONE    | publish result, pulse valid (does not wait for an enable)
module cv_ctrl_scan #(
  parameter int SETTLE = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       clk_en_i,
  input  logic       scan_req_i,
  input  logic [1:0] ctrl_p1_i,
  input  logic [1:0] ctrl_p2_i,
  input  logic [1:0] ctrl_p3_i,
  input  logic [1:0] ctrl_p4_i,
  input  logic [1:0] ctrl_p6_i,
  output logic [1:0] ctrl_p5_o,
  output logic [1:0] ctrl_p8_o,
  output logic [7:0] key_o,
  output logic [7:0] dir_o,
  output logic [3:0] fire_o,
  output logic       busy_o,
  output logic       valid_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEL_KEY = 3'd1,
    S_GAP     = 3'd2,
    S_SEL_JOY = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // Raw samples, still active-low: {p1 nibble, p0 nibble}, nibble = {P1,P2,P3,P4}
  logic [7:0] kp_raw_q, kp_raw_d;
  logic [7:0] joy_raw_q, joy_raw_d;
  logic [1:0] f2_raw_q, f2_raw_d;
  logic [1:0] f1_raw_q, f1_raw_d;

  logic [1:0] p5_q, p5_d;
  logic [1:0] p8_q, p8_d;
  logic [7:0] key_q, key_d;
  logic [7:0] dir_q, dir_d;
  logic [3:0] fire_q, fire_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;

  logic       kp_tc;
  logic       joy_tc;
  logic       done;
  logic       upd;

`ifdef CTRL_SCAN_DEBOUNCE_EN
  logic [19:0] hist_q, hist_d;
  logic [19:0] raw_new;
`endif

  function automatic logic [3:0] decode_key(input logic [3:0] nib);
    logic [3:0] k;
    case (nib)
      4'b0011: k = 4'd0;
      4'b1110: k = 4'd1;
      4'b1101: k = 4'd2;
      4'b0110: k = 4'd3;
      4'b0001: k = 4'd4;
      4'b1001: k = 4'd5;
      4'b0111: k = 4'd6;
      4'b1100: k = 4'd7;
      4'b1000: k = 4'd8;
      4'b1011: k = 4'd9;
      4'b1010: k = 4'd10;
      4'b0101: k = 4'd11;
      4'b0100: k = 4'd12;
      4'b0010: k = 4'd13;
      4'b1111: k = 4'd15;
      default: k = 4'd14;
    endcase
    return k;
  endfunction

  // State register and all datapath flops
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      kp_raw_q  <= '1;
      joy_raw_q <= '1;
      f2_raw_q  <= '1;
      f1_raw_q  <= '1;
      p5_q      <= 2'b11;
      p8_q      <= 2'b11;
      key_q     <= 8'hFF;
      dir_q     <= '0;
      fire_q    <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
`ifdef CTRL_SCAN_DEBOUNCE_EN
      hist_q    <= '1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kp_raw_q  <= kp_raw_d;
      joy_raw_q <= joy_raw_d;
      f2_raw_q  <= f2_raw_d;
      f1_raw_q  <= f1_raw_d;
      p5_q      <= p5_d;
      p8_q      <= p8_d;
      key_q     <= key_d;
      dir_q     <= dir_d;
      fire_q    <= fire_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
`ifdef CTRL_SCAN_DEBOUNCE_EN
      hist_q    <= hist_d;
`endif
    end
  end

  // Next-state and settle down-counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clk_en_i && scan_req_i) begin
          state_d = S_SEL_KEY;
          cnt_d   = CNT_LOAD;
        end
      end
      S_SEL_KEY: begin
        if (clk_en_i) begin
          if (cnt_q == 8'd0) state_d = S_GAP;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (clk_en_i) begin
          state_d = S_SEL_JOY;
          cnt_d   = CNT_LOAD;
        end
      end
      S_SEL_JOY: begin
        if (clk_en_i) begin
          if (cnt_q == 8'd0) state_d = S_DONE;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: selects/busy follow the next state so they change right after the edge
  always_comb begin
    kp_tc  = (state_q == S_SEL_KEY) && clk_en_i && (cnt_q == 8'd0);
    joy_tc = (state_q == S_SEL_JOY) && clk_en_i && (cnt_q == 8'd0);
    done   = (state_q == S_DONE);

    kp_raw_d  = kp_raw_q;
    f2_raw_d  = f2_raw_q;
    joy_raw_d = joy_raw_q;
    f1_raw_d  = f1_raw_q;
    if (kp_tc) begin
      kp_raw_d = {ctrl_p1_i[1], ctrl_p2_i[1], ctrl_p3_i[1], ctrl_p4_i[1],
                  ctrl_p1_i[0], ctrl_p2_i[0], ctrl_p3_i[0], ctrl_p4_i[0]};
      f2_raw_d = ctrl_p6_i;
    end
    if (joy_tc) begin
      joy_raw_d = {ctrl_p1_i[1], ctrl_p2_i[1], ctrl_p3_i[1], ctrl_p4_i[1],
                   ctrl_p1_i[0], ctrl_p2_i[0], ctrl_p3_i[0], ctrl_p4_i[0]};
      f1_raw_d  = ctrl_p6_i;
    end

`ifdef CTRL_SCAN_DEBOUNCE_EN
    raw_new = {kp_raw_q, f2_raw_q, joy_raw_q, f1_raw_q};
    upd     = done && (raw_new == hist_q);
    hist_d  = done ? raw_new : hist_q;
`else
    upd     = done;
`endif

    key_d  = key_q;
    dir_d  = dir_q;
    fire_d = fire_q;
    if (upd) begin
      key_d  = {decode_key(kp_raw_q[7:4]), decode_key(kp_raw_q[3:0])};
      dir_d  = ~joy_raw_q;
      fire_d = {~f2_raw_q[1], ~f1_raw_q[1], ~f2_raw_q[0], ~f1_raw_q[0]};
    end

    // Only one select is ever low, since state_d names a single select state
    p5_d    = (state_d == S_SEL_KEY) ? 2'b00 : 2'b11;
    p8_d    = (state_d == S_SEL_JOY) ? 2'b00 : 2'b11;
    busy_d  = (state_d != S_IDLE);
    valid_d = done;
  end

  assign ctrl_p5_o = p5_q;
  assign ctrl_p8_o = p8_q;
  assign key_o     = key_q;
  assign dir_o     = dir_q;
  assign fire_o    = fire_q;
  assign busy_o    = busy_q;
  assign valid_o   = valid_q;

endmodule
